// File: rtl/mem_lsu.sv
// mem_lsu: byte-serial load/store unit sharing an 8-bit memory port with IF.
// A request of 2^size bytes is issued one byte per granted cycle to base+n
// (address wraps). Load bytes return the cycle after their grant and are
// assembled little-endian, then sign- or zero-extended to DATA_W.
// Ports:
//   clk_in, rst_in (async, active-low)
//   req_*  : request from the pipeline (valid/ready handshake, accepted in IDLE)
//   resp_* : one-cycle completion pulse with load data / error
//   mem_*  : byte-wide shared memory port (req/gnt, we, addr, wdata, rdata)
//   stall_out : pipeline stall while a request is being accepted or in flight
module mem_lsu #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              req_valid_in,
    output logic              req_ready_out,
    input  logic              req_we_in,
    input  logic [1:0]        req_size_in,
    input  logic              req_signed_in,
    input  logic [ADDR_W-1:0] req_addr_in,
    input  logic [DATA_W-1:0] req_wdata_in,
    input  logic [4:0]        req_rd_in,
    output logic              resp_valid_out,
    output logic              resp_rde_out,
    output logic [4:0]        resp_rd_out,
    output logic [DATA_W-1:0] resp_data_out,
    output logic              resp_err_out,
    output logic              mem_req_out,
    input  logic              mem_gnt_in,
    output logic              mem_we_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [7:0]        mem_wdata_out,
    input  logic [7:0]        mem_rdata_in,
    output logic              stall_out
);

    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned SZ_MAX = $clog2(NBYTES);
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [4:0]        rd_q, rd_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              pend_q, pend_d;
    logic [CNT_W-1:0]  lane_q, lane_d;

    logic              size_bad;
    logic              accept;
    logic              issue;
    logic              last_byte;
    int unsigned       ext_bits;
    logic [DATA_W-1:0] keep_mask;
    logic              sign_bit;
    logic [DATA_W-1:0] ext_data;

    // Compared one bit wider so the check stays meaningful when SZ_MAX is 3.
    assign size_bad  = {1'b0, req_size_in} > 3'(SZ_MAX);
    assign accept    = (state_q == IDLE) && req_valid_in;
    assign issue     = (state_q == XFER) && mem_gnt_in;
    assign last_byte = {1'b0, cnt_q} == ((4'd1 << size_q) - 4'd1);

    // State register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_valid_in) state_d = size_bad ? DONE : XFER;
            XFER: if (mem_gnt_in && last_byte) state_d = we_q ? DONE : WAIT;
            WAIT: state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, byte counter and load-byte capture
    always_comb begin
        cnt_d    = cnt_q;
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        err_d    = err_q;
        data_d   = data_q;
        pend_d   = 1'b0;
        lane_d   = lane_q;
        // Byte granted last cycle lands in its lane; lanes are written once
        // per access and the buffer is cleared on accept, so OR is enough.
        if (pend_q) begin
            data_d = data_q | (DATA_W'(mem_rdata_in) << {lane_q, 3'b000});
        end
        if (accept) begin
            cnt_d    = '0;
            we_d     = req_we_in;
            size_d   = req_size_in;
            signed_d = req_signed_in;
            addr_d   = req_addr_in;
            wdata_d  = req_wdata_in;
            rd_d     = req_rd_in;
            err_d    = size_bad;
            data_d   = '0;
        end
        if (issue) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!we_q) begin
                pend_d = 1'b1;
                lane_d = cnt_q;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q    <= '0;
            we_q     <= 1'b0;
            size_q   <= '0;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= '0;
            err_q    <= 1'b0;
            data_q   <= '0;
            pend_q   <= 1'b0;
            lane_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            err_q    <= err_d;
            data_q   <= data_d;
            pend_q   <= pend_d;
            lane_q   <= lane_d;
        end
    end

    // Extend the assembled bytes from bit 8*2^size-1; a full-width access
    // shifts the mask out to zero, which wraps to all-ones after the -1.
    always_comb begin
        ext_bits  = 32'd8 << size_q;
        keep_mask = (DATA_W'(1) << ext_bits) - DATA_W'(1);
        sign_bit  = signed_q & (|(data_q & (DATA_W'(1) << (ext_bits - 32'd1))));
        ext_data  = (data_q & keep_mask) | (sign_bit ? ~keep_mask : '0);
    end

    // Output decode
    always_comb begin
        req_ready_out  = 1'b0;
        stall_out      = 1'b0;
        mem_req_out    = 1'b0;
        mem_we_out     = 1'b0;
        mem_addr_out   = '0;
        mem_wdata_out  = '0;
        resp_valid_out = 1'b0;
        resp_rde_out   = 1'b0;
        resp_rd_out    = '0;
        resp_data_out  = '0;
        resp_err_out   = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_out = 1'b1;
                // Reset must force stall low even while a request is presented.
                stall_out     = req_valid_in & rst_in;
            end
            XFER: begin
                stall_out     = 1'b1;
                mem_req_out   = 1'b1;
                mem_we_out    = we_q;
                mem_addr_out  = addr_q + ADDR_W'(cnt_q);
                mem_wdata_out = 8'(wdata_q >> {cnt_q, 3'b000});
            end
            WAIT: begin
                stall_out = 1'b1;
            end
            DONE: begin
                resp_valid_out = 1'b1;
                resp_rd_out    = rd_q;
                resp_rde_out   = !we_q && !err_q;
                resp_err_out   = err_q;
                resp_data_out  = (we_q || err_q) ? '0 : ext_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: a 32-bit and a 64-bit instance share clock and reset.
// A cycle-schedule model derived from the access latency rules predicts every
// output of both instances each cycle; a byte memory answers the mem port.
module tb_mem_lsu;

    typedef struct packed {
        logic        ready;
        logic        stall;
        logic        mem_req;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [7:0]  mem_wdata;
        logic        resp_valid;
        logic        resp_rde;
        logic        resp_err;
        logic [4:0]  resp_rd;
        logic [63:0] resp_data;
    } obs_t;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [4:0]  rd;
        logic        gnt;
    } drv_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    drv_t d32, d64;
    obs_t o32, o64, x32, x64;
    logic [7:0] rdata32, rdata64;
    logic       chk_en;
    int         cur_cyc;
    int         n_chk = 0;
    int         n_err = 0;

    logic [7:0] mem [logic [31:0]];

    int          seen_cyc [2];
    logic [63:0] seen_data [2];
    logic        seen_rde [2];
    logic        seen_err [2];
    int          nreq [2];
    logic [31:0] iss_addr [2][64];

    // DUT output wires
    logic        a_ready, a_stall, a_mreq, a_mwe, a_rv, a_rde, a_err;
    logic [31:0] a_maddr;
    logic [7:0]  a_mwd;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        b_ready, b_stall, b_mreq, b_mwe, b_rv, b_rde, b_err;
    logic [31:0] b_maddr;
    logic [7:0]  b_mwd;
    logic [4:0]  b_rd;
    logic [63:0] b_data;

    mem_lsu #(.DATA_W(32), .ADDR_W(32)) u_dut32 (
        .clk_in(clk), .rst_in(rst_n),
        .req_valid_in(d32.valid), .req_ready_out(a_ready), .req_we_in(d32.we),
        .req_size_in(d32.size), .req_signed_in(d32.sgn), .req_addr_in(d32.addr),
        .req_wdata_in(d32.wdata[31:0]), .req_rd_in(d32.rd),
        .resp_valid_out(a_rv), .resp_rde_out(a_rde), .resp_rd_out(a_rd),
        .resp_data_out(a_data), .resp_err_out(a_err),
        .mem_req_out(a_mreq), .mem_gnt_in(d32.gnt), .mem_we_out(a_mwe),
        .mem_addr_out(a_maddr), .mem_wdata_out(a_mwd), .mem_rdata_in(rdata32),
        .stall_out(a_stall)
    );

    mem_lsu #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
        .clk_in(clk), .rst_in(rst_n),
        .req_valid_in(d64.valid), .req_ready_out(b_ready), .req_we_in(d64.we),
        .req_size_in(d64.size), .req_signed_in(d64.sgn), .req_addr_in(d64.addr),
        .req_wdata_in(d64.wdata), .req_rd_in(d64.rd),
        .resp_valid_out(b_rv), .resp_rde_out(b_rde), .resp_rd_out(b_rd),
        .resp_data_out(b_data), .resp_err_out(b_err),
        .mem_req_out(b_mreq), .mem_gnt_in(d64.gnt), .mem_we_out(b_mwe),
        .mem_addr_out(b_maddr), .mem_wdata_out(b_mwd), .mem_rdata_in(rdata64),
        .stall_out(b_stall)
    );

    always_comb begin
        o32 = '0;
        o32.ready = a_ready;  o32.stall = a_stall;  o32.mem_req = a_mreq;
        o32.mem_we = a_mwe;   o32.mem_addr = a_maddr; o32.mem_wdata = a_mwd;
        o32.resp_valid = a_rv; o32.resp_rde = a_rde; o32.resp_err = a_err;
        o32.resp_rd = a_rd;   o32.resp_data = {32'h0, a_data};
        o64 = '0;
        o64.ready = b_ready;  o64.stall = b_stall;  o64.mem_req = b_mreq;
        o64.mem_we = b_mwe;   o64.mem_addr = b_maddr; o64.mem_wdata = b_mwd;
        o64.resp_valid = b_rv; o64.resp_rde = b_rde; o64.resp_err = b_err;
        o64.resp_rd = b_rd;   o64.resp_data = b_data;
    end

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    function automatic obs_t idle_rec();
        obs_t r;
        r = '0;
        r.ready = 1'b1;
        return r;
    endfunction

    // Byte memory: writes land on a granted store byte, read data appears the
    // following cycle; any other cycle returns a filler byte.
    always @(posedge clk) begin
        rdata32 <= 8'h5A;
        rdata64 <= 8'hC3;
        if (o32.mem_req && d32.gnt) begin
            if (o32.mem_we) mem[o32.mem_addr] = o32.mem_wdata;
            else rdata32 <= mem_rd(o32.mem_addr);
        end
        if (o64.mem_req && d64.gnt) begin
            if (o64.mem_we) mem[o64.mem_addr] = o64.mem_wdata;
            else rdata64 <= mem_rd(o64.mem_addr);
        end
    end

    task automatic cmp_rec(input string nm, input int idx, input obs_t got, input obs_t want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s outputs cyc=%0d got=%h want=%h", nm, cur_cyc, got, want);
        end
        if (got.resp_valid) begin
            seen_cyc[idx]  = cur_cyc;
            seen_data[idx] = got.resp_data;
            seen_rde[idx]  = got.resp_rde;
            seen_err[idx]  = got.resp_err;
        end
        if (got.mem_req) begin
            nreq[idx]++;
            if (cur_cyc >= 0 && cur_cyc < 64) iss_addr[idx][cur_cyc] = got.mem_addr;
        end
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_rec("dut32", 0, o32, x32);
            cmp_rec("dut64", 1, o64, x64);
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    // One access from acceptance (cycle 0) until the unit is idle again.
    // gnt_low bit c withholds the grant in cycle c; rst_cyc >= 0 pulses reset.
    task automatic run(input bit big, input bit we, input logic [1:0] sz, input bit sgn,
                       input logic [31:0] addr, input logic [63:0] wdata, input logic [4:0] rd,
                       input logic [31:0] gnt_low, input int rst_cyc);
        int nb, dw, k, c, phase;
        bit ok, fin;
        logic [63:0] raw, expd;
        obs_t e;
        drv_t d;
        for (int i = 0; i < 2; i++) begin
            seen_cyc[i] = -1; seen_data[i] = '0; seen_rde[i] = 1'b0;
            seen_err[i] = 1'b0; nreq[i] = 0;
            for (int j = 0; j < 64; j++) iss_addr[i][j] = '0;
        end
        dw  = big ? 64 : 32;
        nb  = 1 << sz;
        ok  = (nb * 8) <= dw;
        raw = '0;
        for (int i = 0; i < nb; i++) raw |= 64'(mem_rd(addr + 32'(i))) << (8 * i);
        expd = raw;
        if (nb < 8 && sgn && raw[8*nb-1]) expd = raw | (~64'd0 << (8 * nb));
        if (!big) expd = expd & 64'h0000_0000_FFFF_FFFF;
        if (we || !ok) expd = '0;
        k = 0; c = 0; phase = 0; fin = 1'b0;
        while (!fin) begin
            @(posedge clk); #1;
            cur_cyc = c;
            d = '0;
            d.gnt = (c < 32) ? !gnt_low[c] : 1'b1;
            e = idle_rec();
            if (rst_cyc >= 0 && c >= rst_cyc) begin
                rst_n = (c == rst_cyc) ? 1'b0 : 1'b1;
                if (c == rst_cyc + 6) fin = 1'b1;
            end else if (c == 0) begin
                d.valid = 1'b1; d.we = we; d.size = sz; d.sgn = sgn;
                d.addr = addr; d.wdata = wdata; d.rd = rd;
                e.stall = 1'b1;
                phase = ok ? 0 : 2;
            end else begin
                case (phase)
                    0: begin
                        e.ready = 1'b0; e.stall = 1'b1; e.mem_req = 1'b1; e.mem_we = we;
                        e.mem_addr = addr + 32'(k);
                        e.mem_wdata = 8'(wdata >> (8 * k));
                        if (d.gnt) begin
                            k++;
                            if (k == nb) phase = we ? 2 : 1;
                        end
                    end
                    1: begin
                        e.ready = 1'b0; e.stall = 1'b1; phase = 2;
                    end
                    2: begin
                        e.ready = 1'b0; e.resp_valid = 1'b1; e.resp_rd = rd;
                        e.resp_rde = !we && ok; e.resp_err = !ok; e.resp_data = expd;
                        phase = 3;
                    end
                    default: fin = 1'b1;
                endcase
            end
            if (big) begin
                d64 = d; x64 = e; d32 = '0; x32 = idle_rec();
            end else begin
                d32 = d; x32 = e; d64 = '0; x64 = idle_rec();
            end
            c++;
            if (c > 60) begin
                n_chk++; n_err++;
                $display("FAIL run_bound cycles=%0d", c);
                fin = 1'b1;
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        d32 = '0; d64 = '0;
        x32 = idle_rec(); x64 = idle_rec();
        chk_en = 1'b0;
        cur_cyc = -1;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_ready32", 64'(o32.ready), 64'd1);
        chk("reset_stall64", 64'(o64.stall), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Signed word load
        mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'hF2;
        run(0, 0, 2'd2, 1, 32'h100, 64'hCAFE_F00D, 5'd5, 32'h0, -1);
        chk("lw_cycle", 64'(seen_cyc[0]), 64'd6);
        chk("lw_data", seen_data[0], 64'hF234_5678);
        chk("lw_rde", 64'(seen_rde[0]), 64'd1);
        chk("lw_addr_c1", 64'(iss_addr[0][1]), 64'h100);
        chk("lw_addr_c4", 64'(iss_addr[0][4]), 64'h103);

        // Byte loads, signed and unsigned
        mem[32'h300] = 8'h80;
        run(0, 0, 2'd0, 1, 32'h300, 64'h0, 5'd9, 32'h0, -1);
        chk("lb_signed", seen_data[0], 64'hFFFF_FF80);
        chk("lb_cycle", 64'(seen_cyc[0]), 64'd3);
        run(0, 0, 2'd0, 0, 32'h300, 64'h0, 5'd9, 32'h0, -1);
        chk("lbu", seen_data[0], 64'h0000_0080);

        // Unaligned signed halfword
        mem[32'h2FF] = 8'h34;
        run(0, 0, 2'd1, 1, 32'h2FF, 64'h0, 5'd3, 32'h0, -1);
        chk("lh_unaligned", seen_data[0], 64'hFFFF_8034);

        // Halfword store
        mem[32'h202] = 8'h11;
        run(0, 1, 2'd1, 0, 32'h200, 64'hDEAD_BEEF, 5'd7, 32'h0, -1);
        chk("sh_byte0", 64'(mem_rd(32'h200)), 64'hEF);
        chk("sh_byte1", 64'(mem_rd(32'h201)), 64'hBE);
        chk("sh_byte2_kept", 64'(mem_rd(32'h202)), 64'h11);
        chk("sh_cycle", 64'(seen_cyc[0]), 64'd3);
        chk("sh_rde", 64'(seen_rde[0]), 64'd0);
        chk("sh_data", seen_data[0], 64'h0);

        // Wrapping word store with grant withheld in cycles 2 and 3
        run(0, 1, 2'd2, 0, 32'hFFFF_FFFE, 64'h4433_2211, 5'd1, 32'h0000_000C, -1);
        chk("sw_cycle", 64'(seen_cyc[0]), 64'd7);
        chk("sw_addr_c2", 64'(iss_addr[0][2]), 64'hFFFF_FFFF);
        chk("sw_addr_c3", 64'(iss_addr[0][3]), 64'hFFFF_FFFF);
        chk("sw_addr_c5", 64'(iss_addr[0][5]), 64'h0);
        chk("sw_addr_c6", 64'(iss_addr[0][6]), 64'h1);
        chk("sw_mem_0", 64'(mem_rd(32'h0)), 64'h33);
        chk("sw_mem_ff", 64'(mem_rd(32'hFFFF_FFFF)), 64'h22);

        // Read it back with grant withheld in cycles 1 and 3
        run(0, 0, 2'd2, 0, 32'hFFFF_FFFE, 64'h0, 5'd2, 32'h0000_000A, -1);
        chk("lw_wrap_data", seen_data[0], 64'h4433_2211);
        chk("lw_wrap_cycle", 64'(seen_cyc[0]), 64'd8);

        // Oversized request on the 32-bit unit
        run(0, 0, 2'd3, 1, 32'h100, 64'h0, 5'd4, 32'h0, -1);
        chk("err_cycle", 64'(seen_cyc[0]), 64'd1);
        chk("err_flag", 64'(seen_err[0]), 64'd1);
        chk("err_no_mem", 64'(nreq[0]), 64'd0);

        // 64-bit doubleword load, then the same access cut by reset
        for (int i = 0; i < 8; i++) mem[32'h400 + 32'(i)] = 8'(i + 1);
        run(1, 0, 2'd3, 0, 32'h400, 64'h0, 5'd10, 32'h0, -1);
        chk("ld_cycle", 64'(seen_cyc[1]), 64'd10);
        chk("ld_data", seen_data[1], 64'h0807_0605_0403_0201);
        run(1, 0, 2'd3, 0, 32'h400, 64'h0, 5'd10, 32'h0, 3);
        chk("ld_rst_noresp", 64'(seen_cyc[1]), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("ld_rst_bytes", 64'(nreq[1]), 64'd2);

        // 64-bit signed byte and a stalled doubleword store
        mem[32'h480] = 8'hFF;
        run(1, 0, 2'd0, 1, 32'h480, 64'h0, 5'd11, 32'h0, -1);
        chk("lb64_signed", seen_data[1], 64'hFFFF_FFFF_FFFF_FFFF);
        run(1, 1, 2'd3, 0, 32'h500, 64'h0123_4567_89AB_CDEF, 5'd12, 32'h0000_0020, -1);
        chk("sd_cycle", 64'(seen_cyc[1]), 64'd10);
        chk("sd_mem_lo", 64'(mem_rd(32'h500)), 64'hEF);
        chk("sd_mem_hi", 64'(mem_rd(32'h507)), 64'h01);

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
